// File: rtl/dec2e_sel_arbiter_if.sv
// Request/decoder-drive bundle between requesters and dec2e_sel_arbiter.
// The lock line exists only when ARB_LOCK_EN is defined.
interface dec2e_sel_arbiter_if;
  logic [1:0] req;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif
  logic       E;
  logic       A0;
  logic       busy;

  modport master (
    output req,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  E, A0, busy
  );

  modport slave (
    input  req,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output E, A0, busy
  );
endinterface

// File: rtl/dec2e_sel_arbiter.sv
// Two-requester round-robin arbiter driving E/A0 of a 1-to-2 decoder, with a
// one-cycle E-low gap between grants. Define ARB_LOCK_EN to add grant extension.
module dec2e_sel_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  dec2e_sel_arbiter_if.slave bus
);

  localparam int unsigned    CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             a0_q, a0_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;

  logic             win_vld;
  logic             win_idx;
  logic             hold_ext;

`ifdef ARB_LOCK_EN
  assign hold_ext = bus.lock;
`else
  assign hold_ext = 1'b0;
`endif

  // Round-robin pick: a tie goes to the index that did not win last time.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    win_vld = 1'b1;
    win_idx = 1'b0;
    case (bus.req)
      2'b01:   win_idx = 1'b0;
      2'b10:   win_idx = 1'b1;
      2'b11:   win_idx = ~last_q;
      default: win_vld = 1'b0;
    endcase
  end

  // State register; outputs are registered alongside so E/busy track the state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      a0_q    <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      a0_q    <= a0_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic. A0 only changes when a new grant starts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    a0_d    = a0_q;
    case (state_q)
      IDLE, GAP: begin
        if (win_vld) begin
          state_d = GRANT;
          cnt_d   = CNT_LOAD;
          last_d  = win_idx;
          a0_d    = win_idx;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Early release beats both the counter and lock.
        if (!bus.req[a0_q]) begin
          state_d = GAP;
        end else if (cnt_q == '0) begin
          if (!hold_ext) state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic, computed from the next state so the registered copies line up with it.
  always_comb begin
    e_d    = (state_d == GRANT);
    busy_d = (state_d != IDLE);
  end

  assign bus.E    = e_q;
  assign bus.A0   = a0_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_dec2e_sel_arbiter.sv
// Scoreboard bench for dec2e_sel_arbiter: stimulus queues expected {E,A0,busy}
// per cycle, a monitor compares after each rising edge.
module tb_dec2e_sel_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dec2e_sel_arbiter_if bus ();

  dec2e_sel_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic  e;
    logic  a0;
    logic  busy;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: E/A0/busy got %b want %b", name, act, exp);
    end
  endtask

  // One cycle: drive inputs on the falling edge and queue the outputs expected after the next rising edge.
  task automatic cyc(input logic rst, input logic [1:0] r, input logic lk,
                     input logic [2:0] exp, input string name);
    @(negedge clk);
    rst_n   = rst;
    bus.req = r;
`ifdef ARB_LOCK_EN
    bus.lock = lk;
`endif
    sb_q.push_back('{exp[2], exp[1], exp[0], name});
  endtask

  task automatic rep(input int n, input logic rst, input logic [1:0] r, input logic lk,
                     input logic [2:0] exp, input string name);
    for (int i = 0; i < n; i++) cyc(rst, r, lk, exp, name);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check(x.name, {bus.E, bus.A0, bus.busy}, {x.e, x.a0, x.busy});
      end
    end
  end

  initial begin : stimulus
    int wait_cyc;
    rst_n   = 1'b0;
    bus.req = 2'b11;
`ifdef ARB_LOCK_EN
    bus.lock = 1'b0;
`endif

    // Reset held with both requests active.
    rep(3, 1'b0, 2'b11, 1'b0, 3'b000, "reset_hold");

    // Single requester 0: 4-cycle grant, gap, regrant, then early release to idle.
    rep(4, 1'b1, 2'b01, 1'b0, 3'b101, "req0_grant");
    cyc(1'b1, 2'b01, 1'b0, 3'b001, "req0_gap");
    cyc(1'b1, 2'b01, 1'b0, 3'b101, "req0_regrant");
    cyc(1'b1, 2'b00, 1'b0, 3'b001, "req0_release");
    cyc(1'b1, 2'b00, 1'b0, 3'b000, "req0_idle");

    // Both held: last grant was 0, so 1 goes first; A0 stays put during gaps.
    rep(4, 1'b1, 2'b11, 1'b0, 3'b111, "rr_g1a");
    cyc(1'b1, 2'b11, 1'b0, 3'b011, "rr_gap1");
    rep(4, 1'b1, 2'b11, 1'b0, 3'b101, "rr_g0");
    cyc(1'b1, 2'b11, 1'b0, 3'b001, "rr_gap2");
    rep(4, 1'b1, 2'b11, 1'b0, 3'b111, "rr_g1b");
    cyc(1'b1, 2'b11, 1'b0, 3'b011, "rr_gap3");
    cyc(1'b1, 2'b00, 1'b0, 3'b010, "rr_idle");

    // Grant to 1 released after two cycles.
    rep(2, 1'b1, 2'b10, 1'b0, 3'b111, "er_grant1");
    cyc(1'b1, 2'b00, 1'b0, 3'b011, "er_gap");
    cyc(1'b1, 2'b00, 1'b0, 3'b010, "er_idle");

    // Reset mid-grant of index 0; afterwards the tie must go to 0 again.
    cyc(1'b1, 2'b01, 1'b0, 3'b101, "mr_grant0");
    cyc(1'b1, 2'b11, 1'b0, 3'b101, "mr_grant0_c2");
    cyc(1'b0, 2'b11, 1'b0, 3'b000, "mr_reset");
    cyc(1'b1, 2'b11, 1'b0, 3'b101, "mr_tie_to_0");
    cyc(1'b1, 2'b00, 1'b0, 3'b001, "mr_release");
    cyc(1'b1, 2'b00, 1'b0, 3'b000, "mr_idle");

`ifdef ARB_LOCK_EN
    // Lock stretches grant 0 past 4 cycles; dropping it ends the grant at cnt 0.
    cyc(1'b0, 2'b11, 1'b1, 3'b000, "lk_reset");
    rep(6, 1'b1, 2'b11, 1'b1, 3'b101, "lk_hold0");
    cyc(1'b1, 2'b11, 1'b0, 3'b001, "lk_gap");
    cyc(1'b1, 2'b11, 1'b0, 3'b111, "lk_grant1");
    cyc(1'b1, 2'b00, 1'b0, 3'b011, "lk_release");
    cyc(1'b1, 2'b00, 1'b0, 3'b010, "lk_idle");
`endif

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
